// File: rtl/color_bounce_pkg.sv
// Shared definitions for the Color Bounce game-state store.
// Holds the default field widths, the power-up values of the platform bank
// and ball color, and a helper that pulls one slot out of a packed vector.
package color_bounce_pkg;

   localparam int DEF_NPLAT = 4;
   localparam int DEF_BW    = 8;
   localparam int DEF_PW    = 7;
   localparam int DEF_CW    = 3;
   localparam int DEF_SW    = 16;

   localparam logic [DEF_NPLAT*DEF_PW-1:0] DEF_PLAT_POS_C = 28'h46F2AEE;
   localparam logic [DEF_NPLAT*DEF_CW-1:0] DEF_PLAT_COL_C = 12'h3BD;
   localparam logic [DEF_CW-1:0]           DEF_BALL_COL_C = 3'b111;

   // Returns slot idx of a packed vector whose slots are w bits wide
   // (slot i at [i*w +: w]); w must not exceed 32.
   function automatic logic [31:0] slot_of(input logic [255:0] vec,
                                           input int idx,
                                           input int w);
      logic [255:0] shifted;
      logic [31:0]  mask;
      shifted = vec >> (idx * w);
      mask    = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return shifted[31:0] & mask;
   endfunction

endpackage

// File: rtl/plat_slot_bank.sv
// Shadow platform bank: NPLAT slots of {position, color}.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   wr_plat, plat_idx     - write one slot with plat_pos_in / plat_col_in
//   scroll                - shift slots down by one, insert new top slot
//   plat_pos_in/col_in    - data for wr_plat or scroll
//   pos_vec, col_vec      - packed shadow contents, slot i at [i*W +: W]
//   drop                  - the wr_plat presented this cycle is discarded
module plat_slot_bank
   import color_bounce_pkg::*;
#(
   parameter int NPLAT = DEF_NPLAT,
   parameter int PW    = DEF_PW,
   parameter int CW    = DEF_CW,
   parameter logic [NPLAT*PW-1:0] DEF_PLAT_POS = DEF_PLAT_POS_C,
   parameter logic [NPLAT*CW-1:0] DEF_PLAT_COL = DEF_PLAT_COL_C,
   parameter int IW    = $clog2(NPLAT)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_plat,
   input  logic [IW-1:0]       plat_idx,
   input  logic                scroll,
   input  logic [PW-1:0]       plat_pos_in,
   input  logic [CW-1:0]       plat_col_in,
   output logic [NPLAT*PW-1:0] pos_vec,
   output logic [NPLAT*CW-1:0] col_vec,
   output logic                drop
);

   logic [PW-1:0] pos_q [NPLAT];
   logic [CW-1:0] col_q [NPLAT];
   logic          idx_ok;

   assign idx_ok = (int'(plat_idx) < NPLAT);

   // Scroll takes the bank for the cycle, so a simultaneous slot write is lost.
   assign drop = wr_plat && (scroll || !idx_ok);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NPLAT; i++) begin
            pos_q[i] <= DEF_PLAT_POS[i*PW +: PW];
            col_q[i] <= DEF_PLAT_COL[i*CW +: CW];
         end
      end else if (scroll) begin
         for (int i = 0; i < NPLAT-1; i++) begin
            pos_q[i] <= pos_q[i+1];
            col_q[i] <= col_q[i+1];
         end
         pos_q[NPLAT-1] <= plat_pos_in;
         col_q[NPLAT-1] <= plat_col_in;
      end else if (wr_plat && idx_ok) begin
         pos_q[plat_idx] <= plat_pos_in;
         col_q[plat_idx] <= plat_col_in;
      end
   end

   always_comb begin
      pos_vec = '0;
      col_vec = '0;
      for (int i = 0; i < NPLAT; i++) begin
         pos_vec[i*PW +: PW] = pos_q[i];
         col_vec[i*CW +: CW] = col_q[i];
      end
   end

endmodule

// File: rtl/color_bounce_state_mem.sv
// Double-buffered game-state store for the Color Bounce engine.
// Game logic updates shadow copies of ball, platforms and score at any time;
// a frame strobe copies the shadow state into the registers the renderer reads.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   wr_ball/ball_in            - shadow ball position write
//   wr_ball_col/ball_col_in    - shadow ball color write
//   wr_plat/plat_idx, scroll,
//   plat_pos_in/plat_col_in    - shadow platform bank updates
//   score_inc/score_amt,
//   score_clr                  - shadow score update (clear wins)
//   frame                      - commit strobe
//   prev_ball_out .. score_out - committed state
//   hiscore_out                - highest committed score since reset
//   commit_done                - pulse in the cycle after a commit
//   wr_drop                    - pulse in the cycle after a discarded wr_plat
module color_bounce_state_mem
   import color_bounce_pkg::*;
#(
   parameter int NPLAT = DEF_NPLAT,
   parameter int BW    = DEF_BW,
   parameter int PW    = DEF_PW,
   parameter int CW    = DEF_CW,
   parameter int SW    = DEF_SW,
   parameter logic [NPLAT*PW-1:0] DEF_PLAT_POS = DEF_PLAT_POS_C,
   parameter logic [NPLAT*CW-1:0] DEF_PLAT_COL = DEF_PLAT_COL_C,
   parameter logic [CW-1:0]       DEF_BALL_COL = DEF_BALL_COL_C
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_ball,
   input  logic [BW-1:0]            ball_in,
   input  logic                     wr_ball_col,
   input  logic [CW-1:0]            ball_col_in,
   input  logic                     wr_plat,
   input  logic [$clog2(NPLAT)-1:0] plat_idx,
   input  logic                     scroll,
   input  logic [PW-1:0]            plat_pos_in,
   input  logic [CW-1:0]            plat_col_in,
   input  logic                     score_inc,
   input  logic [7:0]               score_amt,
   input  logic                     score_clr,
   input  logic                     frame,
   output logic [BW-1:0]            prev_ball_out,
   output logic [BW-1:0]            curr_ball_out,
   output logic [CW-1:0]            color_ball_out,
   output logic [NPLAT*PW-1:0]      position_plats_out,
   output logic [NPLAT*CW-1:0]      color_plats_out,
   output logic [SW-1:0]            score_out,
   output logic [SW-1:0]            hiscore_out,
   output logic                     commit_done,
   output logic                     wr_drop
);

   localparam int IW = $clog2(NPLAT);

   logic [NPLAT*PW-1:0] plat_pos_s;
   logic [NPLAT*CW-1:0] plat_col_s;
   logic                drop_s;
   logic [BW-1:0]       ball_s;
   logic [CW-1:0]       ball_col_s;
   logic [SW-1:0]       score_s;

   // Add at SW+1 bits so the carry flags overflow; clamp instead of wrapping.
   function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a,
                                             input logic [7:0]    b);
      logic [SW:0] sum;
      sum = {1'b0, a} + {{(SW+1-8){1'b0}}, b};
      return sum[SW] ? {SW{1'b1}} : sum[SW-1:0];
   endfunction

   plat_slot_bank #(
      .NPLAT        (NPLAT),
      .PW           (PW),
      .CW           (CW),
      .DEF_PLAT_POS (DEF_PLAT_POS),
      .DEF_PLAT_COL (DEF_PLAT_COL),
      .IW           (IW)
   ) u_bank (
      .clk         (clk),
      .reset       (reset),
      .wr_plat     (wr_plat),
      .plat_idx    (plat_idx),
      .scroll      (scroll),
      .plat_pos_in (plat_pos_in),
      .plat_col_in (plat_col_in),
      .pos_vec     (plat_pos_s),
      .col_vec     (plat_col_s),
      .drop        (drop_s)
   );

   // Shadow copy of ball and score
   always_ff @(posedge clk) begin
      if (reset) begin
         ball_s     <= '0;
         ball_col_s <= DEF_BALL_COL;
         score_s    <= '0;
      end else begin
         if (wr_ball)     ball_s     <= ball_in;
         if (wr_ball_col) ball_col_s <= ball_col_in;
         if (score_clr)      score_s <= '0;
         else if (score_inc) score_s <= sat_add(score_s, score_amt);
      end
   end

   // Committed copy; commits sample the shadow as it stood before this edge
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_ball_out      <= '0;
         curr_ball_out      <= '0;
         color_ball_out     <= DEF_BALL_COL;
         position_plats_out <= DEF_PLAT_POS;
         color_plats_out    <= DEF_PLAT_COL;
         score_out          <= '0;
         hiscore_out        <= '0;
         commit_done        <= 1'b0;
         wr_drop            <= 1'b0;
      end else begin
         if (frame) begin
            prev_ball_out      <= curr_ball_out;
            curr_ball_out      <= ball_s;
            color_ball_out     <= ball_col_s;
            position_plats_out <= plat_pos_s;
            color_plats_out    <= plat_col_s;
            score_out          <= score_s;
            if (score_s > hiscore_out) hiscore_out <= score_s;
         end
         commit_done <= frame;
         wr_drop     <= drop_s;
      end
   end

endmodule

// File: tb/tb_color_bounce_state_mem.sv
module tb_color_bounce_state_mem;
   import color_bounce_pkg::*;

   logic        clk = 1'b0;
   logic        reset, wr_ball, wr_ball_col, wr_plat, scroll;
   logic        score_inc, score_clr, frame;
   logic [7:0]  ball_in, score_amt;
   logic [2:0]  ball_col_in, plat_col_in;
   logic [1:0]  plat_idx;
   logic [6:0]  plat_pos_in;
   logic [7:0]  prev_ball_out, curr_ball_out;
   logic [2:0]  color_ball_out;
   logic [27:0] position_plats_out;
   logic [11:0] color_plats_out;
   logic [15:0] score_out, hiscore_out;
   logic        commit_done, wr_drop;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   color_bounce_state_mem dut (
      .clk(clk), .reset(reset),
      .wr_ball(wr_ball), .ball_in(ball_in),
      .wr_ball_col(wr_ball_col), .ball_col_in(ball_col_in),
      .wr_plat(wr_plat), .plat_idx(plat_idx), .scroll(scroll),
      .plat_pos_in(plat_pos_in), .plat_col_in(plat_col_in),
      .score_inc(score_inc), .score_amt(score_amt), .score_clr(score_clr),
      .frame(frame),
      .prev_ball_out(prev_ball_out), .curr_ball_out(curr_ball_out),
      .color_ball_out(color_ball_out),
      .position_plats_out(position_plats_out), .color_plats_out(color_plats_out),
      .score_out(score_out), .hiscore_out(hiscore_out),
      .commit_done(commit_done), .wr_drop(wr_drop)
   );

   // Behavioural model: shadow state and committed state as plain values
   int m_ball, m_bcol, m_score;
   int m_pos[4], m_col[4];
   int o_prev, o_curr, o_bcol, o_score, o_hi, o_done, o_drop;
   int o_pos[4], o_col[4];
   // Power-up platform slots (slot 0 first), decoded from 28'h46F2AEE / 12'h3BD
   int def_pos[4] = '{110, 85, 60, 35};
   int def_col[4] = '{5, 7, 6, 1};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      if (reset) begin
         m_ball = 0; m_bcol = 7; m_score = 0;
         o_prev = 0; o_curr = 0; o_bcol = 7; o_score = 0; o_hi = 0;
         o_done = 0; o_drop = 0;
         for (int i = 0; i < 4; i++) begin
            m_pos[i] = def_pos[i]; m_col[i] = def_col[i];
            o_pos[i] = def_pos[i]; o_col[i] = def_col[i];
         end
      end else begin
         if (frame) begin
            o_prev = o_curr; o_curr = m_ball; o_bcol = m_bcol; o_score = m_score;
            if (m_score > o_hi) o_hi = m_score;
            for (int i = 0; i < 4; i++) begin
               o_pos[i] = m_pos[i]; o_col[i] = m_col[i];
            end
         end
         o_done = frame ? 1 : 0;
         o_drop = (wr_plat && (scroll || int'(plat_idx) >= 4)) ? 1 : 0;
         if (wr_ball)     m_ball = int'(ball_in);
         if (wr_ball_col) m_bcol = int'(ball_col_in);
         if (scroll) begin
            for (int i = 0; i < 3; i++) begin
               m_pos[i] = m_pos[i+1]; m_col[i] = m_col[i+1];
            end
            m_pos[3] = int'(plat_pos_in); m_col[3] = int'(plat_col_in);
         end else if (wr_plat && int'(plat_idx) < 4) begin
            m_pos[plat_idx] = int'(plat_pos_in);
            m_col[plat_idx] = int'(plat_col_in);
         end
         if (score_clr)      m_score = 0;
         else if (score_inc) m_score = (m_score + int'(score_amt) > 65535) ? 65535
                                       : m_score + int'(score_amt);
      end
   endtask

   task automatic compare_all();
      logic [27:0] ep;
      logic [11:0] ec;
      ep = '0; ec = '0;
      for (int i = 0; i < 4; i++) begin
         ep[i*7 +: 7] = 7'(o_pos[i]);
         ec[i*3 +: 3] = 3'(o_col[i]);
      end
      chk("prev_ball",   64'(prev_ball_out),      64'(o_prev));
      chk("curr_ball",   64'(curr_ball_out),      64'(o_curr));
      chk("ball_col",    64'(color_ball_out),     64'(o_bcol));
      chk("plat_pos",    64'(position_plats_out), 64'(ep));
      chk("plat_col",    64'(color_plats_out),    64'(ec));
      chk("score",       64'(score_out),          64'(o_score));
      chk("hiscore",     64'(hiscore_out),        64'(o_hi));
      chk("commit_done", 64'(commit_done),        64'(o_done));
      chk("wr_drop",     64'(wr_drop),            64'(o_drop));
   endtask

   task automatic idle_in();
      reset = 0; wr_ball = 0; wr_ball_col = 0; wr_plat = 0; scroll = 0;
      score_inc = 0; score_clr = 0; frame = 0;
      ball_in = 0; ball_col_in = 0; plat_idx = 0; plat_pos_in = 0;
      plat_col_in = 0; score_amt = 0;
   endtask

   // Apply current inputs for one edge, then check at the following negedge
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
      idle_in();
   endtask

   task automatic do_reset();
      idle_in(); reset = 1; step();
   endtask

   initial begin
      idle_in();
      @(negedge clk);
      do_reset();

      // Reset then idle
      chk("rst_pos",  64'(position_plats_out), 64'(28'h46F2AEE));
      chk("rst_col",  64'(color_plats_out),    64'(12'h3BD));
      chk("rst_bcol", 64'(color_ball_out),     64'(3'b111));
      repeat (10) step();
      chk("idle_pos",  64'(position_plats_out), 64'(28'h46F2AEE));
      chk("idle_curr", 64'(curr_ball_out),      64'd0);

      // Ball history across two commits
      wr_ball = 1; ball_in = 8'd20; step();
      frame = 1; step();
      chk("c1_done", 64'(commit_done), 64'd1);
      step();
      chk("c1_done_gone", 64'(commit_done), 64'd0);
      wr_ball = 1; ball_in = 8'd25; step();
      frame = 1; step();
      chk("c2_curr", 64'(curr_ball_out), 64'd25);
      chk("c2_prev", 64'(prev_ball_out), 64'd20);

      // Scroll, then scroll colliding with a slot write
      do_reset();
      scroll = 1; plat_pos_in = 7'd90; plat_col_in = 3'b010; step();
      frame = 1; step();
      chk("scr_pos", 64'(position_plats_out), 64'({7'd90, 7'd35, 7'd60, 7'd85}));
      chk("scr_col", 64'(color_plats_out),    64'({3'b010, 3'd1, 3'd6, 3'd7}));
      chk("scr_slot3", 64'(slot_of(256'(position_plats_out), 3, 7)), 64'd90);
      scroll = 1; plat_pos_in = 7'd90; plat_col_in = 3'b010;
      wr_plat = 1; plat_idx = 2'd0; step();
      chk("drop_pulse", 64'(wr_drop), 64'd1);
      frame = 1; step();
      chk("drop_slot0", 64'(slot_of(256'(position_plats_out), 0, 7)), 64'd60);
      chk("drop_gone", 64'(wr_drop), 64'd0);

      // Saturation: preload 16'hFFF0 then add 32
      do_reset();
      repeat (256) begin score_inc = 1; score_amt = 8'd255; step(); end
      score_inc = 1; score_amt = 8'd240; step();
      frame = 1; step();
      chk("pre_fff0", 64'(score_out), 64'h0000_0000_0000_FFF0);
      score_inc = 1; score_amt = 8'd32; step();
      frame = 1; step();
      chk("sat_ffff", 64'(score_out), 64'h0000_0000_0000_FFFF);

      // High score survives a clear
      do_reset();
      score_inc = 1; score_amt = 8'd100; step();
      frame = 1; step();
      score_clr = 1; score_inc = 1; score_amt = 8'd5; step();
      score_inc = 1; score_amt = 8'd40; step();
      frame = 1; step();
      chk("hs_score", 64'(score_out),   64'd40);
      chk("hs_hi",    64'(hiscore_out), 64'd100);

      // Frame coinciding with a write, then reset mid-sequence
      wr_ball = 1; ball_in = 8'd50; step();
      frame = 1; wr_ball = 1; ball_in = 8'd60; step();
      chk("same_cyc_old", 64'(curr_ball_out), 64'd50);
      frame = 1; step();
      chk("same_cyc_new", 64'(curr_ball_out), 64'd60);
      wr_ball = 1; ball_in = 8'd77; score_inc = 1; score_amt = 8'd9; step();
      reset = 1; frame = 1; wr_ball = 1; ball_in = 8'd88; step();
      chk("midrst_curr", 64'(curr_ball_out),      64'd0);
      chk("midrst_hi",   64'(hiscore_out),        64'd0);
      chk("midrst_pos",  64'(position_plats_out), 64'(28'h46F2AEE));
      frame = 1; step();
      chk("midrst_lost", 64'(curr_ball_out), 64'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset       = ($urandom_range(0, 299) == 0);
         wr_ball     = 1'($urandom);
         ball_in     = 8'($urandom);
         wr_ball_col = ($urandom_range(0, 3) == 0);
         ball_col_in = 3'($urandom);
         wr_plat     = ($urandom_range(0, 2) == 0);
         plat_idx    = 2'($urandom);
         scroll      = ($urandom_range(0, 3) == 0);
         plat_pos_in = 7'($urandom);
         plat_col_in = 3'($urandom);
         score_inc   = 1'($urandom);
         score_amt   = 8'($urandom);
         score_clr   = ($urandom_range(0, 40) == 0);
         frame       = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/color_bounce_state_mem.md
# color_bounce_state_mem

Double-buffered game-state store for the Color Bounce engine, generalised to NPLAT platforms and configurable field widths. Game logic writes ball, platform and score updates into shadow registers at any time. A single `frame` strobe commits the shadow copy to the output registers that the VGA renderer reads. The block also scrolls the platform bank, accumulates a saturating score, and tracks a high score across rounds.

## Interface
Parameters:
- `NPLAT`, 4: number of platform slots (≥2).
- `BW`, 8: ball position width.
- `PW`, 7: platform position width.
- `CW`, 3: color width.
- `SW`, 16: score width.
- `DEF_PLAT_POS`, 28'h46F2AEE: reset platform positions, NPLAT*PW bits.
- `DEF_PLAT_COL`, 12'h3BD: reset platform colors, NPLAT*CW bits.
- `DEF_BALL_COL`, 3'b111: reset ball color.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_ball`  in  1  load `ball_in` into the shadow ball position.
- `ball_in`  in  BW  new ball position.
- `wr_ball_col`  in  1  load `ball_col_in` into the shadow ball color.
- `ball_col_in`  in  CW  new ball color.
- `wr_plat`  in  1  write slot `plat_idx` of the shadow bank.
- `plat_idx`  in  $clog2(NPLAT)  slot to write.
- `scroll`  in  1  shift the platform bank and insert a new top slot.
- `plat_pos_in`  in  PW  position for `wr_plat` or `scroll`.
- `plat_col_in`  in  CW  color for `wr_plat` or `scroll`.
- `score_inc`  in  1  add `score_amt` to the shadow score.
- `score_amt`  in  8  increment amount.
- `score_clr`  in  1  zero the shadow score.
- `frame`  in  1  commit strobe.
- `prev_ball_out`  out  BW  committed ball position from the previous frame.
- `curr_ball_out`  out  BW  committed ball position.
- `color_ball_out`  out  CW  committed ball color.
- `position_plats_out`  out  NPLAT*PW  committed positions; slot i at [i*PW +: PW].
- `color_plats_out`  out  NPLAT*CW  committed colors; slot i at [i*CW +: CW].
- `score_out`  out  SW  committed score.
- `hiscore_out`  out  SW  highest committed score since reset.
- `commit_done`  out  1  one-cycle pulse in the cycle after a commit.
- `wr_drop`  out  1  one-cycle pulse when a `wr_plat` is discarded.

## Operation
- Reset values (shadow and output registers alike):
  - ball position 0, `prev_ball_out` 0;
  - ball color DEF_BALL_COL;
  - platforms DEF_PLAT_POS / DEF_PLAT_COL;
  - score 0, `hiscore_out` 0;
  - `commit_done` 0, `wr_drop` 0.
- Reset has priority over every other input, including in the middle of a frame. Shadow writes pending at reset are lost.
- Shadow writes are independent per field and take effect at the clock edge.
- `scroll`, shadow bank only:
  - slot i ← slot i+1 for i < NPLAT-1;
  - slot NPLAT-1 ← {`plat_pos_in`, `plat_col_in`};
  - the old slot 0 is discarded.
- `scroll` and `wr_plat` in the same cycle: the scroll executes, the `wr_plat` is dropped, and `wr_drop` pulses the following cycle.
- `plat_idx` ≥ NPLAT: the write is ignored and `wr_drop` pulses.
- Score:
  - `score_clr` wins over `score_inc`;
  - the add is computed at SW+1 bits and saturates to 2^SW−1;
  - no wrap-around is allowed.
- Commit on `frame`:
  - `prev_ball_out` ← old `curr_ball_out`;
  - every other output ← the shadow value as it stood before this edge;
  - shadow writes in the same cycle stay in the shadow copy and appear at the next commit;
  - `hiscore_out` ← max(`hiscore_out`, pre-edge shadow score);
  - `score_clr` does not affect `hiscore_out`.
- Without `frame`, every output register holds its value. `frame` held high commits on every cycle.

## Timing
- Shadow write latency is 1 cycle, into the shadow copy. Outputs change only at a `frame` edge.
- Commit latency: an output changes at the same edge on which `frame` is sampled high. `commit_done` is high for the following cycle.
- Write-to-output latency is therefore at least 1 `frame` edge after the write edge.
- There is no combinational path from any input to any output.

## Structure
- Shared package `color_bounce_pkg` holds:
  - default widths BW/PW/CW/SW;
  - the default position, platform color and ball color constants;
  - a function that extracts a slot from the packed vector.
- One sub-module, `plat_slot_bank`. It contains the NPLAT shadow slots with write and scroll logic, and produces the packed vectors and the drop flag.
- The top level holds the ball and score shadows, the output registers, commit control and high-score tracking.

## Test plan
- Reset then idle: `position_plats_out` = 28'h46F2AEE, `color_plats_out` = 12'h3BD, `color_ball_out` = 3'b111, all other outputs 0, and no change over 10 cycles without `frame`.
- `wr_ball` 8'd20, then `frame`, then `wr_ball` 8'd25, then `frame`: after the second commit `curr_ball_out` = 25 and `prev_ball_out` = 20. `commit_done` pulses once after each commit.
- `scroll` with pos 7'd90 / col 3'b010, then `frame`: slot 3 = 90/3'b010, slots 0–2 = old slots 1–3. The same scroll together with `wr_plat` idx 0: the write is lost and `wr_drop` pulses.
- Score saturation, SW=16: preload the score to 16'hFFF0, issue `score_inc` 8'd32, then `frame`: `score_out` = 16'hFFFF.
- High score and clear: score 100, `frame`, `score_clr`, score 40, `frame`: `score_out` = 40 and `hiscore_out` = 100.
- `frame` and `wr_ball` in the same cycle: the output keeps the old shadow value and the new value appears only at the next `frame`. Asserting `reset` mid-sequence restores all defaults on the next edge.
